// File: rtl/event_led_stretcher_if.sv
// Event/LED signal bundle between game logic (master) and the LED stretcher (slave).
interface event_led_stretcher_if #(
    parameter int unsigned PEND_W = 3
);
    logic              event_pulse;
    logic              clr_overflow;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output event_pulse, clr_overflow,
        input  led_out, busy, pending, overflow
    );

    modport slave (
        input  event_pulse, clr_overflow,
        output led_out, busy, pending, overflow
    );
endinterface

// File: rtl/event_led_stretcher.sv
// Stretches single-cycle game-event pulses into visible LED flashes with an enforced dark gap,
// queueing events that arrive mid-flash and replaying them in order.
module event_led_stretcher #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned ON_TICKS  = 3,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned PEND_W    = 3
) (
    input logic                  clk_fpga,
    input logic                  reset_n,
    event_led_stretcher_if.slave bus
);
    localparam int unsigned PreW     = $clog2(TICK_DIV);
    localparam int unsigned MaxTicks = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TickW    = $clog2(MaxTicks + 1);

    localparam logic [PreW-1:0]   PreLast = PreW'(TICK_DIV - 1);
    localparam logic [TickW-1:0]  OnLast  = TickW'(ON_TICKS - 1);
    localparam logic [TickW-1:0]  OffLast = TickW'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PendMax = '1;

    typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

    state_e            state_q;
    logic [PreW-1:0]   pre_q;
    logic [TickW-1:0]  tick_cnt_q;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q;
    logic              led_q;
    logic              busy_q;

    logic tick, on_end, gap_end, drop;

    always_comb begin
        tick    = (pre_q == PreLast);
        on_end  = (state_q == StOn) && tick && (tick_cnt_q == OnLast);
        gap_end = (state_q == StGap) && tick && (tick_cnt_q == OffLast);

        pending_d = pending_q;
        drop      = 1'b0;
        if ((state_q != StIdle) && bus.event_pulse) begin
            // At gap end an event either cancels the dequeue or starts the next flash directly.
            if (gap_end) begin
                pending_d = pending_q;
            end else if (pending_q == PendMax) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (gap_end && (pending_q != '0)) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pre_q      <= '0;
            tick_cnt_q <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end

            pre_q <= tick ? '0 : pre_q + PreW'(1);
            if (tick) begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
            end

            // Timers restart on every state entry so each phase has an exact length.
            unique case (state_q)
                StIdle: begin
                    pre_q      <= '0;
                    tick_cnt_q <= '0;
                    if (bus.event_pulse) begin
                        state_q <= StOn;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StOn: begin
                    if (on_end) begin
                        state_q    <= StGap;
                        led_q      <= 1'b0;
                        pre_q      <= '0;
                        tick_cnt_q <= '0;
                    end
                end
                StGap: begin
                    if (gap_end) begin
                        pre_q      <= '0;
                        tick_cnt_q <= '0;
                        if ((pending_q != '0) || bus.event_pulse) begin
                            state_q <= StOn;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
endmodule
